// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD command sequencer: FSM encoding, frame opcodes and reply bytes.
package sd_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_CHECK,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_REPLY,
        ST_REPLY_WAIT
    } state_t;

    localparam logic [7:0] OPC_WRITE = 8'h7A;
    localparam logic [7:0] OPC_READ  = 8'h6F;
    localparam logic [7:0] OPC_PING  = 8'h70;

    localparam logic [7:0] RPL_OK  = 8'h4B;
    localparam logic [7:0] RPL_ERR = 8'h45;
    localparam logic [7:0] RPL_TMO = 8'h54;

    function automatic logic is_frame_opc(input logic [7:0] b);
        return (b == OPC_WRITE) || (b == OPC_READ);
    endfunction

endpackage

// File: rtl/sd_timeout_counter.sv
// Inactivity timer: counts enabled cycles since the last clear and flags the last allowed cycle.
module sd_timeout_counter #(
    parameter int unsigned LIMIT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TC = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    assign expired = en && (cnt == TC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Parses UART command frames, drives SD driver write/read requests, sources write data and replies.
//
// state         | meaning
// IDLE          | waiting for an opcode byte
// ADDR          | shifting in 4 address bytes, MSB first
// LEN           | shifting in 2 length bytes, MSB first
// CHECK         | validate length, load request registers
// WR_REQ        | WR_STB high until WR_ACK
// WR_DATA       | stream write bytes until remaining hits 0
// RD_REQ        | RD_STB high until RD_ACK
// REPLY         | wait TX_RDY, pulse TX_STB with reply byte
// REPLY_WAIT    | wait TX_ACK
module sd_cmd_sequencer
    import sd_ctrl_pkg::*;
#(
    parameter int unsigned CLK_MHZ    = 50,
    parameter int unsigned TIMEOUT_US = 10000,
    parameter logic [7:0]  SEED       = 8'h41
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX_STB,
    input  logic [7:0]  RX_DAT,
    output logic        RX_ACK,
    output logic        TX_STB,
    output logic [7:0]  TX_DAT,
    input  logic        TX_ACK,
    input  logic        TX_RDY,
    output logic        WR_STB,
    output logic [31:0] WR_ADDR,
    output logic [31:0] WR_LENGTH,
    input  logic        WR_ACK,
    output logic        WD_STB,
    output logic [7:0]  WD_DATA,
    input  logic        WD_ACK,
    output logic        RD_STB,
    output logic [31:0] RD_ADDR,
    output logic [31:0] RD_LENGTH,
    input  logic        RD_ACK,
    output logic        BUSY
);

    state_t      state, state_next;
    logic [7:0]  reply_code;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] addr_sh;
    logic [15:0] len_sh;
    logic [15:0] remaining;
    logic        tmo_clr, tmo_en, tmo_exp;

    assign RX_ACK  = RX_STB;
    assign tmo_en  = (state == ST_ADDR) || (state == ST_LEN) ||
                     (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign tmo_clr = (state_next != state) ||
                     (RX_STB && ((state == ST_ADDR) || (state == ST_LEN)));

    sd_timeout_counter #(
        .LIMIT(CLK_MHZ * TIMEOUT_US)
    ) u_tmo (
        .clk     (CLK),
        .rst     (RST),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            byte_cnt  <= 2'd0;
            is_write  <= 1'b0;
            addr_sh   <= '0;
            len_sh    <= '0;
            WR_ADDR   <= '0;
            WR_LENGTH <= '0;
            RD_ADDR   <= '0;
            RD_LENGTH <= '0;
            WD_DATA   <= SEED;
            remaining <= '0;
            TX_DAT    <= '0;
        end else begin
            state <= state_next;
            BUSY  <= (state_next != ST_IDLE);
            if ((state_next == ST_REPLY) && (state != ST_REPLY)) begin
                TX_DAT <= reply_code;
            end
            case (state)
                ST_IDLE: begin
                    if (RX_STB) begin
                        is_write <= (RX_DAT == OPC_WRITE);
                        byte_cnt <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (RX_STB) begin
                        addr_sh  <= {addr_sh[23:0], RX_DAT};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_LEN: begin
                    if (RX_STB) begin
                        len_sh   <= {len_sh[7:0], RX_DAT};
                        byte_cnt <= (byte_cnt == 2'd1) ? 2'd0 : byte_cnt + 2'd1;
                    end
                end
                ST_CHECK: begin
                    if (len_sh != 16'd0) begin
                        if (is_write) begin
                            WR_ADDR   <= addr_sh;
                            WR_LENGTH <= {16'd0, len_sh};
                            WD_DATA   <= SEED;
                            remaining <= len_sh;
                        end else begin
                            RD_ADDR   <= addr_sh;
                            RD_LENGTH <= {16'd0, len_sh};
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (WD_STB && WD_ACK) begin
                        WD_DATA   <= WD_DATA + 8'd1;
                        remaining <= remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame bytes take priority over a timeout landing in the same cycle.
    always_comb begin
        state_next = state;
        reply_code = RPL_OK;
        case (state)
            ST_IDLE: begin
                if (RX_STB) begin
                    if (is_frame_opc(RX_DAT)) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_REPLY;
                        reply_code = (RX_DAT == OPC_PING) ? RPL_OK : RPL_ERR;
                    end
                end
            end
            ST_ADDR: begin
                if (RX_STB) begin
                    if (byte_cnt == 2'd3) state_next = ST_LEN;
                end else if (tmo_exp) begin
                    state_next = ST_REPLY;
                    reply_code = RPL_TMO;
                end
            end
            ST_LEN: begin
                if (RX_STB) begin
                    if (byte_cnt == 2'd1) state_next = ST_CHECK;
                end else if (tmo_exp) begin
                    state_next = ST_REPLY;
                    reply_code = RPL_TMO;
                end
            end
            ST_CHECK: begin
                if (len_sh == 16'd0) begin
                    state_next = ST_REPLY;
                    reply_code = RPL_ERR;
                end else begin
                    state_next = is_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (tmo_exp) begin
                    state_next = ST_REPLY;
                    reply_code = RPL_TMO;
                end else if (WR_ACK) begin
                    state_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (remaining == 16'd0) state_next = ST_REPLY;
            end
            ST_RD_REQ: begin
                if (tmo_exp) begin
                    state_next = ST_REPLY;
                    reply_code = RPL_TMO;
                end else if (RD_ACK) begin
                    state_next = ST_REPLY;
                end
            end
            ST_REPLY: begin
                if (TX_RDY) state_next = ST_REPLY_WAIT;
            end
            ST_REPLY_WAIT: begin
                if (TX_ACK) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        WR_STB = (state == ST_WR_REQ) && !tmo_exp;
        RD_STB = (state == ST_RD_REQ) && !tmo_exp;
        WD_STB = (state == ST_WR_DATA) && (remaining != 16'd0);
        TX_STB = (state == ST_REPLY) && TX_RDY;
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: behavioural UART/driver responders plus hand-computed checks.
module tb_sd_cmd_sequencer;

    localparam int unsigned LIMIT = 40;

    logic        CLK = 1'b0;
    logic        RST;
    logic        RX_STB;
    logic [7:0]  RX_DAT;
    logic        RX_ACK;
    logic        TX_STB;
    logic [7:0]  TX_DAT;
    logic        TX_ACK;
    logic        TX_RDY;
    logic        WR_STB;
    logic [31:0] WR_ADDR;
    logic [31:0] WR_LENGTH;
    logic        WR_ACK;
    logic        WD_STB;
    logic [7:0]  WD_DATA;
    logic        WD_ACK;
    logic        RD_STB;
    logic [31:0] RD_ADDR;
    logic [31:0] RD_LENGTH;
    logic        RD_ACK;
    logic        BUSY;

    int n_chk = 0;
    int n_bad = 0;

    int         tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;
    bit         tx_prev = 1'b0;
    int         wr_cyc = 0, rd_cyc = 0, wd_acks = 0;
    int         wr_run = 0, rd_run = 0;
    int         wr_ack_delay = 3;
    int         rd_ack_delay = 5;
    bit         wd_ack_en = 1'b0;
    logic [7:0] wd_log[$];

    sd_cmd_sequencer #(
        .CLK_MHZ    (1),
        .TIMEOUT_US (LIMIT),
        .SEED       (8'h41)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_STB    (RX_STB),
        .RX_DAT    (RX_DAT),
        .RX_ACK    (RX_ACK),
        .TX_STB    (TX_STB),
        .TX_DAT    (TX_DAT),
        .TX_ACK    (TX_ACK),
        .TX_RDY    (TX_RDY),
        .WR_STB    (WR_STB),
        .WR_ADDR   (WR_ADDR),
        .WR_LENGTH (WR_LENGTH),
        .WR_ACK    (WR_ACK),
        .WD_STB    (WD_STB),
        .WD_DATA   (WD_DATA),
        .WD_ACK    (WD_ACK),
        .RD_STB    (RD_STB),
        .RD_ADDR   (RD_ADDR),
        .RD_LENGTH (RD_LENGTH),
        .RD_ACK    (RD_ACK),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // UART and card-driver responders; inputs change on the falling edge.
    initial begin
        TX_ACK = 1'b0;
        TX_RDY = 1'b1;
        WR_ACK = 1'b0;
        RD_ACK = 1'b0;
        WD_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            TX_ACK  = tx_prev;
            tx_prev = TX_STB;
            WD_ACK  = wd_ack_en;
            if (TX_STB) begin
                tx_cnt++;
                tx_last = TX_DAT;
            end
            if (WR_STB) begin
                wr_cyc++;
                wr_run++;
            end else begin
                wr_run = 0;
            end
            WR_ACK = WR_STB && (wr_ack_delay != 0) && (wr_run == wr_ack_delay);
            if (RD_STB) begin
                rd_cyc++;
                rd_run++;
            end else begin
                rd_run = 0;
            end
            RD_ACK = RD_STB && (rd_ack_delay != 0) && (rd_run == rd_ack_delay);
            if (WD_STB && WD_ACK) begin
                wd_acks++;
                wd_log.push_back(WD_DATA);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_STB = 1'b1;
        RX_DAT = b;
        #1;
        chk("rx_ack", 32'(RX_ACK), 32'd1);
        @(negedge CLK);
        RX_STB = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] opc, input logic [31:0] a, input logic [15:0] l);
        send_byte(opc);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(l[15:8]);
        send_byte(l[7:0]);
    endtask

    task automatic wait_tx(input string tag, input int tx0, input int max_cyc,
                           input logic [7:0] exp, output int lat);
        int i;
        for (i = 0; i < max_cyc && tx_cnt == tx0; i++) begin
            @(posedge CLK);
            #3;
        end
        lat = i;
        for (int j = 0; j < 20 && BUSY !== 1'b0; j++) begin
            @(posedge CLK);
            #3;
        end
        chk({tag, "_replies"}, 32'(tx_cnt - tx0), 32'd1);
        chk({tag, "_reply"}, 32'(tx_last), 32'(exp));
        chk({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    initial begin
        int tx0, wr0, rd0, wa0, s, lat;
        RST    = 1'b1;
        RX_STB = 1'b0;
        RX_DAT = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_wd_data", 32'(WD_DATA), 32'h41);
        chk("rst_tx_dat", 32'(TX_DAT), 32'h0);
        chk("rst_strobes", 32'({WR_STB, RD_STB, WD_STB, TX_STB}), 32'h0);
        chk("rst_wr_addr", WR_ADDR, 32'h0);
        chk("rst_rd_len", RD_LENGTH, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // ping
        tx0 = tx_cnt; wr0 = wr_cyc; rd0 = rd_cyc;
        send_byte(8'h70);
        chk("ping_busy", 32'(BUSY), 32'd1);
        wait_tx("ping", tx0, 20, 8'h4B, lat);
        chk("ping_no_req", 32'((wr_cyc - wr0) + (rd_cyc - rd0)), 32'd0);

        // 3-byte write, WR_ACK on third strobe cycle
        wd_ack_en = 1'b1; wr_ack_delay = 3;
        tx0 = tx_cnt; wr0 = wr_cyc; wa0 = wd_acks; s = wd_log.size();
        send_cmd(8'h7A, 32'h0000_0001, 16'h0003);
        wait_tx("wr3", tx0, 60, 8'h4B, lat);
        chk("wr3_addr", WR_ADDR, 32'h1);
        chk("wr3_len", WR_LENGTH, 32'd3);
        chk("wr3_stb_cycles", 32'(wr_cyc - wr0), 32'd3);
        chk("wr3_acks", 32'(wd_acks - wa0), 32'd3);
        chk("wr3_b0", 32'(wd_log[s]), 32'h41);
        chk("wr3_b1", 32'(wd_log[s+1]), 32'h42);
        chk("wr3_b2", 32'(wd_log[s+2]), 32'h43);
        chk("wr3_wd_stb", 32'(WD_STB), 32'd0);
        chk("wr3_wd_data", 32'(WD_DATA), 32'h44);

        // read, RD_ACK on fifth strobe cycle
        rd_ack_delay = 5;
        tx0 = tx_cnt; wr0 = wr_cyc; rd0 = rd_cyc;
        send_cmd(8'h6F, 32'h1234_5678, 16'h01F4);
        wait_tx("rd", tx0, 60, 8'h4B, lat);
        chk("rd_addr", RD_ADDR, 32'h1234_5678);
        chk("rd_len", RD_LENGTH, 32'd500);
        chk("rd_stb_cycles", 32'(rd_cyc - rd0), 32'd5);
        chk("rd_no_wr", 32'(wr_cyc - wr0), 32'd0);

        // unknown opcode
        tx0 = tx_cnt;
        send_byte(8'h78);
        wait_tx("bad_opc", tx0, 20, 8'h45, lat);

        // zero-length write
        tx0 = tx_cnt; wr0 = wr_cyc;
        send_cmd(8'h7A, 32'h0000_0001, 16'h0000);
        wait_tx("len0", tx0, 20, 8'h45, lat);
        chk("len0_no_wr", 32'(wr_cyc - wr0), 32'd0);
        chk("len0_len_held", WR_LENGTH, 32'd3);

        // stalled frame in ADDR
        tx0 = tx_cnt;
        send_byte(8'h6F);
        send_byte(8'h01);
        wait_tx("tmo_addr", tx0, 3 * LIMIT, 8'h54, lat);
        chk("tmo_addr_latency", 32'(lat >= 40 && lat <= 42), 32'd1);
        tx0 = tx_cnt;
        send_byte(8'h70);
        wait_tx("ping_after_tmo", tx0, 20, 8'h4B, lat);

        // read request never acknowledged
        rd_ack_delay = 0;
        tx0 = tx_cnt; rd0 = rd_cyc;
        send_cmd(8'h6F, 32'h0000_0005, 16'h0008);
        wait_tx("tmo_rd", tx0, 4 * LIMIT, 8'h54, lat);
        chk("tmo_rd_stb_cycles", 32'(rd_cyc - rd0), 32'(LIMIT - 1));
        chk("tmo_rd_addr", RD_ADDR, 32'h5);

        // reset in the middle of a 256-byte write
        wr_ack_delay = 1;
        wa0 = wd_acks;
        send_cmd(8'h7A, 32'h0000_0002, 16'h0100);
        for (int i = 0; i < 100 && (wd_acks - wa0) < 2; i++) begin
            @(posedge CLK);
            #3;
        end
        chk("mid_two_bytes", 32'((wd_acks - wa0) >= 2), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_rst_wd_stb", 32'(WD_STB), 32'd0);
        chk("mid_rst_wd_data", 32'(WD_DATA), 32'h41);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // full 256-byte write, data wraps FF -> 00
        tx0 = tx_cnt; wa0 = wd_acks; s = wd_log.size();
        send_cmd(8'h7A, 32'h0000_0002, 16'h0100);
        wait_tx("wr256", tx0, 600, 8'h4B, lat);
        chk("wr256_len", WR_LENGTH, 32'd256);
        chk("wr256_acks", 32'(wd_acks - wa0), 32'd256);
        chk("wr256_b190", 32'(wd_log[s+190]), 32'hFF);
        chk("wr256_b191", 32'(wd_log[s+191]), 32'h00);
        chk("wr256_b255", 32'(wd_log[s+255]), 32'h40);
        chk("wr256_wd_data", 32'(WD_DATA), 32'h41);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Controller between the UART byte stream and the SD card driver. It parses framed commands from the UART receive handshake and issues write or read requests with address and length on the driver's request ports. During writes it sources the write-data stream. It sends a one-byte status reply on the UART transmit handshake.

Parameters:
CLK_MHZ, 50, clock frequency in MHz; used to scale the timeout.
TIMEOUT_US, 10000, maximum gap between frame bytes, and maximum wait for WR_ACK/RD_ACK, in microseconds.
SEED, 8'h41, first write-data byte of every write command.

Ports:
CLK  in  1  system clock; the block has one clock.
RST  in  1  reset; synchronous, active-high.
RX_STB  in  1  UART received byte valid (one-cycle pulse).
RX_DAT  in  8  UART received byte.
RX_ACK  out  1  combinational, equal to RX_STB; every byte is consumed.
TX_STB  out  1  reply byte strobe (one-cycle pulse).
TX_DAT  out  8  reply byte.
TX_ACK  in  1  UART accepted the byte.
TX_RDY  in  1  UART transmitter idle.
WR_STB  out  1  write request to the card driver.
WR_ADDR  out  32  write block address.
WR_LENGTH  out  32  write byte count.
WR_ACK  in  1  driver accepted the write request.
WD_STB  out  1  write data valid.
WD_DATA  out  8  write data byte.
WD_ACK  in  1  driver consumed WD_DATA this cycle.
RD_STB  out  1  read request.
RD_ADDR  out  32  read block address.
RD_LENGTH  out  32  read byte count.
RD_ACK  in  1  driver accepted the read request.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset, applied on any CLK edge with RST=1 including mid-command:
  - state=IDLE.
  - All strobes = 0 and BUSY = 0.
  - Address, length and TX_DAT = 0.
  - WD_DATA = SEED.
  - Byte and timeout counters = 0.
- Frame format: opcode, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], LEN[15:8], LEN[7:0]. LEN is zero-extended to 32 bits.
- Opcodes:
  - 'z' (8'h7A) = write.
  - 'o' (8'h6F) = read.
  - 'p' (8'h70) = ping: reply 'K' immediately, with no address or length bytes.
  - Any other opcode: reply 'E'.
- States:
  - IDLE: on RX_STB:
    - 'z' or 'o' → ADDR.
    - 'p' → REPLY with 'K'.
    - Other → REPLY with 'E'.
  - ADDR: shift in 4 bytes, MSB first → LEN.
  - LEN: shift in 2 bytes → CHECK.
  - CHECK (1 cycle):
    - LEN==0 → REPLY 'E'.
    - Write → WR_REQ: load WR_ADDR and WR_LENGTH, WD_DATA=SEED, remaining=LEN.
    - Read → RD_REQ: load RD_ADDR and RD_LENGTH.
  - WR_REQ: WR_STB held high until WR_ACK is sampled high. WR_STB drops the next cycle → WR_DATA.
  - WR_DATA:
    - WD_STB = (remaining != 0).
    - Each cycle with WD_STB && WD_ACK: WD_DATA += 1 (wraps 8'hFF → 8'h00) and remaining -= 1.
    - When remaining reaches 0, WD_STB drops in the same cycle the count hits 0 → REPLY 'K'.
    - No timeout in this state.
  - RD_REQ: RD_STB held until RD_ACK is sampled → REPLY 'K'. Read data returns through the driver's result path, not through this block.
  - REPLY: wait for TX_RDY. Then pulse TX_STB for 1 cycle with TX_DAT = reply → REPLY_WAIT.
  - REPLY_WAIT: wait for TX_ACK → IDLE.
- Timeout:
  - Counter limit = CLK_MHZ*TIMEOUT_US cycles; the counter is wide enough for that limit.
  - Cleared on every accepted frame byte and on entry to each state.
  - Counts in ADDR, LEN, WR_REQ and RD_REQ.
  - At the limit: drop any strobe in that same cycle → REPLY 'T'. Partial frame contents are discarded.
- Address and length registers are updated only by the shift-in during ADDR/LEN and by the load in CHECK. They hold their value after a command completes.
- RX bytes arriving in any state other than IDLE, ADDR or LEN are acknowledged and discarded; they produce no reply.
- In ADDR/LEN, a byte and a timeout expiry in the same cycle: the byte wins and the counter clears.
- Driver ack without a pending strobe is ignored.
- WD_ACK outside WR_DATA is ignored.
- BUSY is registered and reflects the current state.

Decomposition:
- Shared package sd_ctrl_pkg holds:
  - State encoding.
  - Opcode constants OPC_WRITE, OPC_READ, OPC_PING.
  - Reply constants RPL_OK='K', RPL_ERR='E', RPL_TMO='T'.
- One natural sub-module: sd_timeout_counter (clear/enable inputs, expiry output, parameterised limit).
- Parser, request handshake and data sourcing stay in one FSM.

Test Plan:
- Send 'p' → one TX_STB with TX_DAT=8'h4B ('K'); BUSY returns to 0 after TX_ACK; no WR_STB or RD_STB.
- Send 'z',00,00,00,01,00,03; WR_ACK 2 cycles after WR_STB; WD_ACK every cycle → WR_ADDR=1 and WR_LENGTH=3; WD_DATA sequence 41,42,43, exactly 3 acks then WD_STB=0; reply 'K'.
- Send 'o',12,34,56,78,01,F4; RD_ACK delayed 5 cycles → RD_STB high for exactly 5 cycles, RD_ADDR=32'h12345678, RD_LENGTH=500; reply 'K'.
- Send 'x' → reply 'E'. Send 'z',0,0,0,1,0,0 → reply 'E' with no WR_STB.
- Send 'o',01 then silence for TIMEOUT_US → reply 'T'. A following 'p' → 'K', proving the parser recovered.
- Assert RST during WR_DATA after 2 of 256 bytes → next cycle WD_STB=0, WD_DATA=8'h41, BUSY=0. A new write of 256 bytes wraps WD_DATA from FF to 00 at byte 191.
